i2s_transmitter: RTL and testbench

- Serializes the synthesizer's 32-bit stereo sample word (left in [31:16], right in [15:0]) into a standard Philips I2S stream (BCLK, LRCLK, SDATA) for the external audio DAC.
- Generates the per-frame sample request that clocks the synthesizer. It sits directly downstream of it in the audio peripheral.
- Buffers one sample, reports underrun/overrun, and starts/stops only on frame boundaries.

---
 rtl/i2s_transmitter.sv | 128 ++++++++++++
 tb/tb_i2s_transmitter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_transmitter.sv
// Philips I2S serializer for the synthesizer's 32-bit stereo word.
// One-sample holding buffer, per-frame sample request, sticky status flags.
module i2s_transmitter #(
  parameter int BCLK_DIV = 4
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [31:0] InputData,
  input  logic        DataValid,
  input  logic        ClearStatus,
  output logic        SampleRequest,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        SDATA,
  output logic        Underrun,
  output logic        Overrun
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    r_state;
  logic [DW-1:0] r_div_cnt;
  logic [5:0]    r_bit_cnt;
  logic          r_bclk;
  logic          r_lrclk;
  logic [63:0]   r_frame;
  logic [31:0]   r_hold;
  logic          r_full;
  logic          r_under;
  logic          r_over;
  logic          r_sreq;

  logic          w_tick;
  logic          w_fall;
  logic          w_end;
  logic          w_load;
  logic          w_stop;
  logic [5:0]    w_nxt_bit;
  logic [63:0]   w_new_frame;

  assign w_tick    = (r_state == RUN) &&
                     (r_div_cnt == DW'(BCLK_DIV - 1));
  assign w_fall    = w_tick && r_bclk;
  assign w_end     = w_fall && (r_bit_cnt == 6'd63);
  assign w_load    = ((r_state == IDLE) || w_end) && Enable;
  assign w_stop    = w_end && !Enable;
  assign w_nxt_bit = r_bit_cnt + 6'd1;

  // Each 32-bit slot: one delay bit, 16 data bits, then zero padding.
  assign w_new_frame = r_full ?
    {1'b0, r_hold[31:16], 16'h0000, r_hold[15:0], 15'h0000} :
    64'd0;

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_under <= 1'b0;
      r_over  <= 1'b0;
      r_sreq  <= 1'b0;
    end else begin
      r_sreq <= w_load;
      if (DataValid)
        r_hold <= InputData;
      if (DataValid)
        r_full <= 1'b1;
      else if (w_load)
        r_full <= 1'b0;
      // A word arriving with a load is not an overrun: the load drains the old one.
      if (DataValid && r_full && !w_load)
        r_over <= 1'b1;
      else if (ClearStatus)
        r_over <= 1'b0;
      if (w_load && !r_full)
        r_under <= 1'b1;
      else if (ClearStatus)
        r_under <= 1'b0;
    end
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_frame   <= '0;
    end else if (w_load) begin
      r_state   <= RUN;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_frame   <= w_new_frame;
    end else if (w_stop) begin
      r_state   <= IDLE;
      r_div_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
      r_frame   <= '0;
    end else if (r_state == RUN) begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
        if (w_fall) begin
          r_bit_cnt <= w_nxt_bit;
          r_frame   <= {r_frame[62:0], 1'b0};
          r_lrclk   <= w_nxt_bit[5];
        end
      end else begin
        r_div_cnt <= r_div_cnt + DW'(1);
      end
    end
  end

  assign SampleRequest = r_sreq;
  assign BCLK          = r_bclk;
  assign LRCLK         = r_lrclk;
  assign SDATA         = r_frame[63];
  assign Underrun      = r_under;
  assign Overrun       = r_over;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at BCLK_DIV=2.
// Frames are captured on BCLK high and compared to hand-built words.
module tb_i2s_transmitter;

  localparam int D = 2;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic [31:0] InputData = '0;
  logic        DataValid = 1'b0;
  logic        ClearStatus = 1'b0;
  logic        SampleRequest;
  logic        BCLK;
  logic        LRCLK;
  logic        SDATA;
  logic        Underrun;
  logic        Overrun;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  i2s_transmitter #(.BCLK_DIV(D)) dut (
    .MasterCLK    (MasterCLK),
    .Reset        (Reset),
    .Enable       (Enable),
    .InputData    (InputData),
    .DataValid    (DataValid),
    .ClearStatus  (ClearStatus),
    .SampleRequest(SampleRequest),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .SDATA        (SDATA),
    .Underrun     (Underrun),
    .Overrun      (Overrun)
  );

  always #5 MasterCLK = ~MasterCLK;
  always @(posedge MasterCLK) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_sreq(input int max, output bit found,
                           output int at);
    found = 1'b0;
    at = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge MasterCLK);
      if (SampleRequest) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // Called on the negedge right after the load edge.
  task automatic capture(input int drop_at,
                         output logic [63:0] dat,
                         output logic [63:0] lr,
                         output bit bok);
    bok = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 0) repeat (D) @(negedge MasterCLK);
      else repeat (2 * D) @(negedge MasterCLK);
      dat[63-k] = SDATA;
      lr[63-k] = LRCLK;
      if (!BCLK) bok = 1'b0;
      if (k == drop_at) Enable = 1'b0;
    end
  endtask

  localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;

  initial begin
    logic [5:0]  acc;
    logic [63:0] dat;
    logic [63:0] lr;
    bit          bok;
    bit          found;
    int          t1;
    int          t2;

    // Reset held with inputs toggling
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge MasterCLK);
      DataValid = i[0];
      Enable = i[1];
      InputData = 32'hDEAD_0000 + 32'(i);
      #1;
      acc |= {SampleRequest, BCLK, LRCLK, SDATA, Underrun, Overrun};
    end
    check("rst_outs", 64'(acc), 64'd0);

    @(negedge MasterCLK);
    DataValid = 1'b0;
    Enable = 1'b0;
    Reset = 1'b1;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge MasterCLK);
      acc |= {SampleRequest, BCLK, LRCLK, SDATA, Underrun, Overrun};
    end
    check("idle_outs", 64'(acc), 64'd0);

    // Single frame A5C3 / 0F0F
    DataValid = 1'b1;
    InputData = 32'hA5C3_0F0F;
    @(negedge MasterCLK);
    DataValid = 1'b0;
    Enable = 1'b1;
    wait_sreq(5, found, t1);
    check("f1_sreq", 64'(found), 64'd1);
    capture(-1, dat, lr, bok);
    check("f1_data", dat, 64'h52E1_8000_0787_8000);
    check("f1_lrclk", lr, LR_EXP);
    check("f1_bclk", 64'(bok), 64'd1);
    check("f1_under", 64'(Underrun), 64'd0);
    check("f1_over", 64'(Overrun), 64'd0);

    // Second frame has no data: underrun
    wait_sreq(10, found, t2);
    check("f2_sreq", 64'(found), 64'd1);
    check("period", 64'(t2 - t1), 64'd256);
    check("f2_under", 64'(Underrun), 64'd1);
    check("f2_sdata", 64'(SDATA), 64'd0);
    ClearStatus = 1'b1;
    @(negedge MasterCLK);
    ClearStatus = 1'b0;
    check("under_clr", 64'(Underrun), 64'd0);

    // Overrun: two words before the next load
    DataValid = 1'b1;
    InputData = 32'h1111_2222;
    @(negedge MasterCLK);
    InputData = 32'h3333_4444;
    @(negedge MasterCLK);
    DataValid = 1'b0;
    check("overrun", 64'(Overrun), 64'd1);
    check("f2_under_hold", 64'(Underrun), 64'd0);

    // Frame 3 carries 3333/4444, Enable dropped at bit 10
    wait_sreq(300, found, t1);
    check("f3_sreq", 64'(found), 64'd1);
    check("f3_under", 64'(Underrun), 64'd0);
    capture(10, dat, lr, bok);
    check("f3_data", dat, 64'h1999_8000_2222_0000);
    check("f3_lrclk", lr, LR_EXP);
    check("f3_bclk", 64'(bok), 64'd1);
    wait_sreq(300, found, t2);
    check("stop_no_sreq", 64'(found), 64'd0);
    check("stop_outs", 64'({BCLK, LRCLK, SDATA}), 64'd0);

    // Reset mid-frame at bit 40
    Enable = 1'b1;
    wait_sreq(5, found, t1);
    check("f4_sreq", 64'(found), 64'd1);
    repeat (2 * D * 40 + D) @(negedge MasterCLK);
    check("f4_bit40_lr", 64'(LRCLK), 64'd1);
    Reset = 1'b0;
    #1;
    check("async_rst", 64'({SampleRequest, BCLK, LRCLK, SDATA,
                            Underrun, Overrun}), 64'd0);
    @(negedge MasterCLK);
    Reset = 1'b1;
    Enable = 1'b0;
    @(negedge MasterCLK);
    DataValid = 1'b1;
    InputData = 32'hBEEF_1234;
    @(negedge MasterCLK);
    DataValid = 1'b0;
    Enable = 1'b1;
    wait_sreq(5, found, t1);
    check("f5_sreq", 64'(found), 64'd1);
    capture(-1, dat, lr, bok);
    check("f5_data", dat, 64'h5F77_8000_091A_0000);
    check("f5_lrclk", lr, LR_EXP);
    check("f5_under", 64'(Underrun), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
